// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// opcodes, funct codes, ALU controls and FSM state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ERROR    = 4'd12
    } state_e;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps alu_op and R-type funct to a 3-bit ALU control;
// flags funct values with no defined operation.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    always_comb begin
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (alu_op)
            AOP_SUB:   ALUControl = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: illegal    = 1'b1;
                endcase
            end
            default:   ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath with a memory
// wait watchdog and a retired-instruction counter.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MEM_TIMEOUT  = 15,
    parameter int TRAP_ILLEGAL = 1,
    parameter int EN_JUMP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCEn,
    output logic             IorD,
    output logic             Memwrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [1:0]       PCsrc,
    output logic [2:0]       ALUControl,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            r_state;
    state_e            w_next;
    state_e            w_trap;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;
    logic              w_mem;
    logic              w_timeout;
    logic              w_illegal;
    logic [1:0]        w_alu_op;
    logic [2:0]        w_alu_ctl;

    assign w_mem     = is_mem_state(r_state);
    assign w_timeout = w_mem && !mem_ready && (r_wait == WAIT_LAST);
    assign w_trap    = (TRAP_ILLEGAL != 0) ? S_ERROR : S_FETCH;

    always_comb begin
        w_alu_op = AOP_ADD;
        if (r_state == S_EXECUTE)
            w_alu_op = AOP_FUNCT;
        else if (r_state == S_BRANCH)
            w_alu_op = AOP_SUB;
    end

    alu_decoder u_alu_dec (
        .funct      (funct),
        .alu_op     (w_alu_op),
        .ALUControl (w_alu_ctl),
        .illegal    (w_illegal)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = (EN_JUMP != 0) ? S_JUMP : w_trap;
                    default:      w_next = w_trap;
                endcase
            end
            S_MEMADR:
                w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEMWRITE: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_EXECUTE: begin
                if (w_illegal && (TRAP_ILLEGAL != 0))
                    w_next = S_ERROR;
                else
                    w_next = S_ALUWB;
            end
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                w_next = S_FETCH;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_ERROR;
        endcase
    end

    // Any state change (memory entry or completion) restarts the wait count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem && !mem_ready)
                r_wait <= r_wait + 1'b1;
            if ((w_next == S_FETCH) && (r_state != S_FETCH))
                r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        PCEn       = 1'b0;
        IorD       = 1'b0;
        Memwrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUsrcA    = 1'b0;
        ALUsrcB    = 2'b00;
        PCsrc      = 2'b00;
        ALUControl = w_alu_ctl;
        unique case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUsrcB = 2'b01;
                IRWrite = mem_ready & rst;
                PCEn    = mem_ready & rst;
            end
            S_DECODE:  ALUsrcB = 2'b10;
            S_MEMADR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                Memwrite = 1'b1;
            end
            S_EXECUTE: ALUsrcA = 1'b1;
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUsrcA = 1'b1;
                PCsrc   = 2'b01;
                PCEn    = zero;
            end
            S_ADDIEX: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCsrc = 2'b10;
                PCEn  = 1'b1;
            end
            S_ERROR:   ALUControl = 3'b000;
            default:   ALUControl = 3'b000;
        endcase
    end

    assign err         = (r_state == S_ERROR);
    assign instr_count = r_count;

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameters: CNT_W, default 16, width of retired-instruction counter; MEM_TIMEOUT, default 15, max wait cycles per memory access; TRAP_ILLEGAL, default 1, illegal opcode enters ERROR (1) or retires as NOP (0); EN_JUMP, default 1, j supported (0: j is illegal).
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction [31:26] from datapath IR.
- funct  in  6  instruction [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access requested.
- PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA  out  1 each  datapath controls.
- ALUsrcB  out  2  ALU B select: 00 reg, 01 const 1, 10 sign-ext imm.
- PCsrc  out  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- err  out  1  ERROR state.
- instr_count  out  CNT_W  retired instructions.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR; outputs are decoded from state and, where stated, mem_ready/zero.
REQ-004 SHALL drive each control output 0 and ALUsrcB/PCsrc 00, ALUControl 010 in every state unless listed below.
REQ-005 FETCH: mem_req=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUControl=010; IRWrite=1 and PCEn=1 only in the cycle mem_ready=1; advance to DECODE on mem_ready, else hold.
REQ-006 DECODE: ALUsrcB=10, ALUControl=010; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 (EN_JUMP=1) -> JUMP, other -> ERROR if TRAP_ILLEGAL=1 else FETCH (retired).
REQ-007 MEMADR: ALUsrcA=1, ALUsrcB=10, ALUControl=010; -> MEMREAD (lw) or MEMWRITE (sw).
REQ-008 MEMREAD: mem_req=1, IorD=1; on mem_ready -> MEMWB, else hold. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-009 MEMWRITE: mem_req=1, IorD=1, Memwrite=1 held until mem_ready; -> FETCH on mem_ready.
REQ-010 EXECUTE: ALUsrcA=1, ALUsrcB=00, ALUControl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); undefined funct -> ERROR if TRAP_ILLEGAL=1 else ALUControl=010 and continue. -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-011 BRANCH: ALUsrcA=1, ALUsrcB=00, ALUControl=110, PCsrc=01, PCEn=zero -> FETCH.
REQ-012 ADDIEX: ALUsrcA=1, ALUsrcB=10, ALUControl=010 -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-013 JUMP: PCsrc=10, PCEn=1 -> FETCH.
REQ-014 Watchdog: wait counter clears on entry to any memory state and on mem_ready; increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0; reaching MEM_TIMEOUT with mem_ready=0 -> ERROR. mem_ready in that same cycle wins.
REQ-015 ERROR: err=1, all controls 0, mem_req=0; exited only by reset.
REQ-016 instr_count SHALL increment by 1 on every transition into FETCH from a non-FETCH state (including NOP retire), wrapping from 2^CNT_W-1 to 0.
REQ-017 mem_ready outside memory states SHALL be ignored.

Reset
REQ-018 rst=0 SHALL asynchronously force state FETCH, wait counter 0, instr_count 0, err 0; outputs take FETCH values (mem_req=1, IRWrite=PCEn=0 while rst=0 via gating).
REQ-019 Reset mid-access SHALL abandon the access; no write strobe asserted after rst falls.

Structure
REQ-020 Opcode, funct, ALUControl encodings and state enum SHALL live in shared package mips_pkg.
REQ-021 Funct decode SHALL be sub-module alu_decoder (funct, alu_op in; ALUControl, illegal out).

Verification
REQ-022 lw with mem_ready after 2 wait cycles in FETCH and MEMREAD -> 9 cycles, RegWrite+MemtoReg in MEMWB, instr_count=1.
REQ-023 beq with zero=1 -> PCEn=1, PCsrc=01 in BRANCH; zero=0 -> PCEn=0; instr_count increments both cases.
REQ-024 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> err=1 on cycle 16, stays until rst.
REQ-025 opcode 111111, TRAP_ILLEGAL=1 -> ERROR after DECODE; TRAP_ILLEGAL=0 -> FETCH, instr_count+1.
REQ-026 CNT_W=4, 17 add instructions -> instr_count=1 (wrap); rst low mid-MEMWRITE -> Memwrite=0 immediately, state FETCH.
